cpu_ctrl_fsm: RTL and testbench

//   Multi-cycle control unit that sequences the 8-bit CPU datapath (regfile, ALU, PC, cpu_out reg).

---
 rtl/cpu_ctrl_pkg.sv | 70 +++++++
 rtl/cpu_ctrl_decode.sv | 58 +++++
 rtl/cpu_ctrl_fsm.sv | 214 +++++++++++++++++++++
 tb/tb_cpu_ctrl_fsm.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_ctrl_pkg
// Description : Shared types and constants for the CPU control unit:
//               FSM states, opcodes, ALU operations, next-state classes
//               produced by the decoder, and instruction field positions.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_ctrl_pkg;

    // Defaults for the control unit parameters
    localparam int c_iw_default       = 16;
    localparam int c_wait_max_default = 15;

    // Instruction field positions (16-bit instruction word)
    localparam int c_opc_msb = 15;
    localparam int c_opc_lsb = 12;
    localparam int c_rd_msb  = 11;
    localparam int c_rd_lsb  = 10;
    localparam int c_rs_msb  = 9;
    localparam int c_rs_lsb  = 8;
    localparam int c_imm_msb = 7;
    localparam int c_imm_lsb = 0;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    // Opcodes 4'hB..4'hE are intentionally absent: they decode as illegal
    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_ADD  = 4'h1,
        OP_SUB  = 4'h2,
        OP_AND  = 4'h3,
        OP_OR   = 4'h4,
        OP_ADDI = 4'h5,
        OP_LD   = 4'h6,
        OP_ST   = 4'h7,
        OP_BEQ  = 4'h8,
        OP_JMP  = 4'h9,
        OP_OUT  = 4'hA,
        OP_HALT = 4'hF
    } opcode_t;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_op_t;

    // What the FSM does after EXEC, as classified by the decoder
    typedef enum logic [2:0] {
        NC_FETCH = 3'd0,
        NC_WB    = 3'd1,
        NC_MEM   = 3'd2,
        NC_BEQ   = 3'd3,
        NC_JMP   = 3'd4,
        NC_OUT   = 3'd5,
        NC_HALT  = 3'd6
    } nclass_t;

endpackage
`default_nettype wire

// File: rtl/cpu_ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module      : cpu_ctrl_decode
// Description : Purely combinational opcode decoder. Maps the latched opcode
//               to ALU operation, ALU operand select, the post-EXEC action
//               class and an illegal-opcode flag.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_ctrl_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [3:0] i_opcode,
    output alu_op_t    o_alu_op,
    output logic       o_alu_src,
    output nclass_t    o_nclass,
    output logic       o_illegal
);

    // Opcode table; undefined opcodes behave as NOP but raise o_illegal
    always_comb begin
        o_alu_op  = ALU_ADD;
        o_alu_src = 1'b0;
        o_nclass  = NC_FETCH;
        o_illegal = 1'b0;
        case (i_opcode)
            OP_NOP:  o_nclass = NC_FETCH;
            OP_ADD:  o_nclass = NC_WB;
            OP_SUB: begin
                o_alu_op = ALU_SUB;
                o_nclass = NC_WB;
            end
            OP_AND: begin
                o_alu_op = ALU_AND;
                o_nclass = NC_WB;
            end
            OP_OR: begin
                o_alu_op = ALU_OR;
                o_nclass = NC_WB;
            end
            OP_ADDI: begin
                o_alu_src = 1'b1;
                o_nclass  = NC_WB;
            end
            // Address is rs + imm for both memory operations
            OP_LD, OP_ST: begin
                o_alu_src = 1'b1;
                o_nclass  = NC_MEM;
            end
            OP_BEQ:  o_nclass = NC_BEQ;
            OP_JMP:  o_nclass = NC_JMP;
            OP_OUT:  o_nclass = NC_OUT;
            OP_HALT: o_nclass = NC_HALT;
            default: o_illegal = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/cpu_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module      : cpu_ctrl_fsm
// Description : Multi-cycle control unit for the 8-bit CPU datapath. Fetches
//               instructions over a req/ready handshake, decodes them and
//               drives datapath enables/selects per state. A wait counter
//               halts the core with bus_err when memory stalls too long.
//               Optional retired-instruction counter: CPU_CTRL_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_ctrl_fsm
    import cpu_ctrl_pkg::*;
#(
    parameter int IW       = c_iw_default,
    parameter int WAIT_MAX = c_wait_max_default
) (
    input  logic          CLK,
    input  logic          reset,
    input  logic [IW-1:0] instr,
    input  logic          zero,
    input  logic          mem_ready,
    output logic          mem_req,
    output logic          mem_we,
    output logic          addr_sel,
    output logic          ir_load,
    output logic          pc_inc,
    output logic          pc_load,
    output logic          reg_we,
    output logic          wb_sel,
    output logic          alu_src,
    output logic [1:0]    alu_op,
    output logic          out_en,
    output logic          halted,
    output logic          illegal,
    output logic          bus_err
`ifdef CPU_CTRL_PERF_EN
    ,
    output logic [15:0]   instr_count
`endif
);

    localparam int                  c_wait_w    = $clog2(WAIT_MAX + 1);
    localparam logic [c_wait_w-1:0] c_wait_last = c_wait_w'(WAIT_MAX - 1);

    state_t              r_state;
    state_t              w_next_state;
    logic [3:0]          r_opcode;
    logic [c_wait_w-1:0] r_wait;
    logic                r_bus_err;
    logic                w_timeout;
    logic                w_is_ld;

    alu_op_t             w_dec_alu_op;
    logic                w_dec_alu_src;
    nclass_t             w_dec_nclass;
    logic                w_dec_illegal;

    // Operand fields are consumed by the datapath, not by the controller
    logic                w_unused_fields;
    assign w_unused_fields = ^instr[c_rd_msb:c_imm_lsb];

    cpu_ctrl_decode u_decode (
        .i_opcode  (r_opcode),
        .o_alu_op  (w_dec_alu_op),
        .o_alu_src (w_dec_alu_src),
        .o_nclass  (w_dec_nclass),
        .o_illegal (w_dec_illegal)
    );

    assign w_is_ld = (r_opcode == OP_LD);

    // Timeout fires on the WAIT_MAX-th consecutive unanswered request cycle
    assign w_timeout = ((r_state == S_FETCH) || (r_state == S_MEM)) &&
                       !mem_ready && (r_wait == c_wait_last);

    assign bus_err = r_bus_err;

    // State register
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Opcode is captured on the completing FETCH handshake only
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_opcode <= 4'h0;
        end else if ((r_state == S_FETCH) && mem_ready) begin
            r_opcode <= instr[c_opc_msb:c_opc_lsb];
        end
    end

    // Counts stalled request cycles; any other cycle clears it, so every
    // entry into FETCH or MEM starts from zero
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_wait <= '0;
        end else if (mem_req && !mem_ready) begin
            r_wait <= r_wait + c_wait_w'(1);
        end else begin
            r_wait <= '0;
        end
    end

    // Sticky bus-error flag, cleared only by reset
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_bus_err <= 1'b0;
        end else if (w_timeout) begin
            r_bus_err <= 1'b1;
        end
    end

`ifdef CPU_CTRL_PERF_EN
    logic [15:0] r_instr_count;
    assign instr_count = r_instr_count;

    // Retired-instruction counter: one per EXEC cycle, saturating
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_instr_count <= 16'h0000;
        end else if ((r_state == S_EXEC) && (r_instr_count != 16'hFFFF)) begin
            r_instr_count <= r_instr_count + 16'd1;
        end
    end
`endif

    // Next-state and datapath control decode
    always_comb begin
        w_next_state = r_state;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        addr_sel     = 1'b0;
        ir_load      = 1'b0;
        pc_inc       = 1'b0;
        pc_load      = 1'b0;
        reg_we       = 1'b0;
        wb_sel       = 1'b0;
        alu_src      = 1'b0;
        alu_op       = 2'b00;
        out_en       = 1'b0;
        halted       = 1'b0;
        illegal      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_next_state = S_FETCH;
            end
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_load      = 1'b1;
                    pc_inc       = 1'b1;
                    w_next_state = S_DECODE;
                end else if (w_timeout) begin
                    w_next_state = S_HALT;
                end
            end
            S_DECODE: begin
                w_next_state = S_EXEC;
            end
            S_EXEC: begin
                alu_op  = w_dec_alu_op;
                alu_src = w_dec_alu_src;
                illegal = w_dec_illegal;
                case (w_dec_nclass)
                    NC_WB:   w_next_state = S_WB;
                    NC_MEM:  w_next_state = S_MEM;
                    NC_HALT: w_next_state = S_HALT;
                    NC_BEQ: begin
                        pc_load      = zero;
                        w_next_state = S_FETCH;
                    end
                    NC_JMP: begin
                        pc_load      = 1'b1;
                        w_next_state = S_FETCH;
                    end
                    NC_OUT: begin
                        out_en       = 1'b1;
                        w_next_state = S_FETCH;
                    end
                    default: w_next_state = S_FETCH;
                endcase
            end
            S_MEM: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                mem_we   = (r_opcode == OP_ST);
                if (mem_ready) begin
                    w_next_state = w_is_ld ? S_WB : S_FETCH;
                end else if (w_timeout) begin
                    w_next_state = S_HALT;
                end
            end
            S_WB: begin
                reg_we       = 1'b1;
                wb_sel       = w_is_ld;
                alu_op       = w_dec_alu_op;
                alu_src      = w_dec_alu_src;
                w_next_state = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_ctrl_fsm
// Description : Self-checking bench for cpu_ctrl_fsm. A vector table runs
//               every opcode with zero-wait memory; hand-written sequences
//               cover memory stalls, halt, timeout and asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_ctrl_fsm;

    // Output vector layout:
    // [14]mem_req [13]mem_we [12]addr_sel [11]ir_load [10]pc_inc [9]pc_load
    // [8]reg_we [7]wb_sel [6]alu_src [5:4]alu_op [3]out_en [2]halted
    // [1]illegal [0]bus_err
    localparam logic [14:0] c_req = 15'h4000;
    localparam logic [14:0] c_we  = 15'h2000;
    localparam logic [14:0] c_as  = 15'h1000;
    localparam logic [14:0] c_irl = 15'h0800;
    localparam logic [14:0] c_pci = 15'h0400;
    localparam logic [14:0] c_pcl = 15'h0200;
    localparam logic [14:0] c_rwe = 15'h0100;
    localparam logic [14:0] c_wbs = 15'h0080;
    localparam logic [14:0] c_src = 15'h0040;
    localparam logic [14:0] c_sub = 15'h0010;
    localparam logic [14:0] c_and = 15'h0020;
    localparam logic [14:0] c_or  = 15'h0030;
    localparam logic [14:0] c_out = 15'h0008;
    localparam logic [14:0] c_hlt = 15'h0004;
    localparam logic [14:0] c_ill = 15'h0002;
    localparam logic [14:0] c_ber = 15'h0001;
    localparam logic [14:0] c_fetch_ok = c_req | c_irl | c_pci;

    logic        CLK = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] instr = 16'h0000;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_req, mem_we, addr_sel, ir_load, pc_inc, pc_load;
    logic        reg_we, wb_sel, alu_src, out_en, halted, illegal, bus_err;
    logic [1:0]  alu_op;
`ifdef CPU_CTRL_PERF_EN
    logic [15:0] instr_count;
`endif
    logic [14:0] outs;

    int n_cmp = 0;
    int n_err = 0;

    assign outs = {mem_req, mem_we, addr_sel, ir_load, pc_inc, pc_load, reg_we,
                   wb_sel, alu_src, alu_op, out_en, halted, illegal, bus_err};

    cpu_ctrl_fsm dut (
        .CLK         (CLK),
        .reset       (reset),
        .instr       (instr),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .addr_sel    (addr_sel),
        .ir_load     (ir_load),
        .pc_inc      (pc_inc),
        .pc_load     (pc_load),
        .reg_we      (reg_we),
        .wb_sel      (wb_sel),
        .alu_src     (alu_src),
        .alu_op      (alu_op),
        .out_en      (out_en),
        .halted      (halted),
        .illegal     (illegal),
        .bus_err     (bus_err)
`ifdef CPU_CTRL_PERF_EN
        ,
        .instr_count (instr_count)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [15:0] ins;
        logic        z;
        logic [14:0] e_exec;
        int          n_post;
        logic [14:0] e_p1;
        logic [14:0] e_p2;
    } vec_t;

    vec_t tbl[16];

    task automatic check(input string name, input logic [14:0] exp);
        n_cmp++;
        if (outs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (time %0t)", name, outs, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, then sample
    task automatic cyc(input logic rdy, input logic [15:0] ins, input logic z,
                       input logic [14:0] exp, input string name);
        @(negedge CLK);
        mem_ready = rdy;
        instr     = ins;
        zero      = z;
        #1;
        check(name, exp);
    endtask

    // Asynchronous reset pulse away from clock edges, then release into IDLE
    task automatic do_reset(input string name);
        #2;
        reset = 1'b0;
        mem_ready = 1'b0;
        #1;
        check({name, "_async"}, 15'h0000);
        @(negedge CLK);
        #1;
        check({name, "_held"}, 15'h0000);
        @(negedge CLK);
        reset = 1'b1;
        #1;
        check({name, "_idle"}, 15'h0000);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{16'h1400, 1'b0, 15'h0000, 1, c_rwe,                 15'h0};
        tbl[1]  = '{16'h2600, 1'b0, c_sub,    1, c_rwe | c_sub,         15'h0};
        tbl[2]  = '{16'h3100, 1'b0, c_and,    1, c_rwe | c_and,         15'h0};
        tbl[3]  = '{16'h4200, 1'b0, c_or,     1, c_rwe | c_or,          15'h0};
        tbl[4]  = '{16'h5A07, 1'b0, c_src,    1, c_rwe | c_src,         15'h0};
        tbl[5]  = '{16'h6405, 1'b0, c_src,    2, c_req | c_as,          c_rwe | c_wbs | c_src};
        tbl[6]  = '{16'h7405, 1'b0, c_src,    1, c_req | c_we | c_as,   15'h0};
        tbl[7]  = '{16'h8010, 1'b1, c_pcl,    0, 15'h0,                 15'h0};
        tbl[8]  = '{16'h8010, 1'b0, 15'h0000, 0, 15'h0,                 15'h0};
        tbl[9]  = '{16'h9020, 1'b0, c_pcl,    0, 15'h0,                 15'h0};
        tbl[10] = '{16'hA100, 1'b0, c_out,    0, 15'h0,                 15'h0};
        tbl[11] = '{16'h0000, 1'b0, 15'h0000, 0, 15'h0,                 15'h0};
        tbl[12] = '{16'hC000, 1'b0, c_ill,    0, 15'h0,                 15'h0};
        tbl[13] = '{16'hB000, 1'b0, c_ill,    0, 15'h0,                 15'h0};
        tbl[14] = '{16'hE000, 1'b1, c_ill,    0, 15'h0,                 15'h0};
        tbl[15] = '{16'hD000, 1'b0, c_ill,    0, 15'h0,                 15'h0};

        // Reset held for two cycles, then IDLE, then FETCH
        cyc(1'b0, 16'h0000, 1'b0, 15'h0000, "reset_low_1");
        cyc(1'b0, 16'h0000, 1'b0, 15'h0000, "reset_low_2");
        @(negedge CLK);
        reset = 1'b1;
        #1;
        check("idle_after_reset", 15'h0000);
        cyc(1'b0, 16'h0000, 1'b0, c_req, "fetch_after_idle");

        // Every opcode with zero-wait memory; each row's FETCH check also
        // confirms the previous instruction returned to FETCH on time
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, tbl[i].ins, tbl[i].z, c_fetch_ok, $sformatf("row%0d_fetch", i));
            cyc(1'b1, 16'h0000, tbl[i].z, 15'h0000, $sformatf("row%0d_decode", i));
            cyc(1'b1, 16'h0000, tbl[i].z, tbl[i].e_exec, $sformatf("row%0d_exec", i));
            if (tbl[i].n_post > 0)
                cyc(1'b1, 16'h0000, tbl[i].z, tbl[i].e_p1, $sformatf("row%0d_post1", i));
            if (tbl[i].n_post > 1)
                cyc(1'b1, 16'h0000, tbl[i].z, tbl[i].e_p2, $sformatf("row%0d_post2", i));
        end

        // LD with memory answering after 3 stalled cycles in MEM
        cyc(1'b1, 16'h6405, 1'b0, c_fetch_ok, "ld_fetch");
        cyc(1'b1, 16'h0000, 1'b0, 15'h0000, "ld_decode");
        cyc(1'b1, 16'h0000, 1'b0, c_src, "ld_exec");
        for (int i = 0; i < 3; i++)
            cyc(1'b0, 16'h0000, 1'b0, c_req | c_as, $sformatf("ld_mem_wait%0d", i));
        cyc(1'b1, 16'h0000, 1'b0, c_req | c_as, "ld_mem_ready");
        cyc(1'b1, 16'h0000, 1'b0, c_rwe | c_wbs | c_src, "ld_wb");

        // ST stalled one cycle short of the timeout still completes
        cyc(1'b1, 16'h7405, 1'b0, c_fetch_ok, "st_fetch");
        cyc(1'b1, 16'h0000, 1'b0, 15'h0000, "st_decode");
        cyc(1'b1, 16'h0000, 1'b0, c_src, "st_exec");
        for (int i = 0; i < 14; i++)
            cyc(1'b0, 16'h0000, 1'b0, c_req | c_we | c_as, $sformatf("st_mem_wait%0d", i));
        cyc(1'b1, 16'h0000, 1'b0, c_req | c_we | c_as, "st_mem_ready");

        // HALT instruction: absorbing state, memory activity ignored
        cyc(1'b1, 16'hF000, 1'b0, c_fetch_ok, "halt_fetch");
        cyc(1'b1, 16'h0000, 1'b0, 15'h0000, "halt_decode");
        cyc(1'b1, 16'h0000, 1'b0, 15'h0000, "halt_exec");
        cyc(1'b1, 16'h0000, 1'b0, c_hlt, "halt_1");
        cyc(1'b1, 16'h1400, 1'b0, c_hlt, "halt_2");
        cyc(1'b0, 16'h0000, 1'b0, c_hlt, "halt_3");
        do_reset("rst_from_halt");

        // Fetch never answered: 15 stalled cycles then HALT with bus_err
        for (int i = 0; i < 15; i++)
            cyc(1'b0, 16'h0000, 1'b0, c_req, $sformatf("to_wait%0d", i));
        cyc(1'b0, 16'h0000, 1'b0, c_hlt | c_ber, "to_halt_1");
        cyc(1'b1, 16'h0000, 1'b0, c_hlt | c_ber, "to_halt_2");
        do_reset("rst_from_timeout");

        // Fetch answered after 14 stalls proceeds normally
        for (int i = 0; i < 14; i++)
            cyc(1'b0, 16'h0000, 1'b0, c_req, $sformatf("f14_wait%0d", i));
        cyc(1'b1, 16'h0000, 1'b0, c_fetch_ok, "f14_ready");
        cyc(1'b1, 16'h0000, 1'b0, 15'h0000, "f14_decode");
        cyc(1'b1, 16'h0000, 1'b0, 15'h0000, "f14_exec");

        // Reset in the middle of a stalled fetch drops mem_req at once
        for (int i = 0; i < 5; i++)
            cyc(1'b0, 16'h0000, 1'b0, c_req, $sformatf("mid_wait%0d", i));
        do_reset("rst_mid_wait");
        cyc(1'b0, 16'h0000, 1'b0, c_req, "fetch_after_mid_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
